// File: rtl/dfe_pkg.sv
// dfe_pkg: shared CIC sizing constants and the interpolation-factor clamp.
package dfe_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int N_STAGES = 3;
    localparam int K_MAX = 4;
    localparam int ACC_W = DATA_WIDTH + (N_STAGES - 1) * K_MAX;

    function automatic logic [4:0] clip_k(input logic [4:0] f, input int kmax);
        return (f > kmax) ? 5'(kmax) : f;
    endfunction
endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: registered wrap-around accumulator with synchronous clear.
module cic_integrator
    import dfe_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);
    always_ff @(posedge CLK) acc <= (RST | clr) ? '0 : acc + din;
endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator, R = 2^k, combs at the low rate,
// zero-stuffing upsample register, registered integrators, unity-gain output shift.
module cic_interpolator #(
    parameter int DATA_WIDTH = dfe_pkg::DATA_WIDTH,
    parameter int N_STAGES = dfe_pkg::N_STAGES,
    parameter int K_MAX = dfe_pkg::K_MAX
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4:0]            Interpolation_Factor,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  underrun
);
    localparam int AW = DATA_WIDTH + (N_STAGES - 1) * K_MAX;
    localparam int PW = K_MAX > 0 ? K_MAX : 1;
    logic [PW-1:0] phase, mask;
    logic [4:0] k_reg, k_eff, k_nxt;
    logic [AW-1:0] dly [N_STAGES];
    logic [AW-1:0] stg [N_STAGES+1];
    logic [AW-1:0] acc [N_STAGES+1];
    logic [AW-1:0] up_reg;
    logic signed [AW-1:0] shifted;
    logic [2:0] vcnt;
    logic clr;

    assign k_eff = dfe_pkg::clip_k(Interpolation_Factor, K_MAX);
    assign in_ready = phase == '0;
    assign underrun = in_ready & ~in_valid & ~RST;
    assign clr = in_ready & (k_eff != k_reg);
    assign k_nxt = in_ready ? k_eff : k_reg;
    assign mask = PW'((32'd1 << k_nxt) - 32'd1);
    assign shifted = $signed(acc[N_STAGES]) >>> (2 * k_reg);
    assign acc[0] = up_reg;

    // A factor change restarts the filter, so the comb history is ignored on that sample.
    always_comb begin
        stg[0] = in_valid ? AW'($signed(data_in)) : '0;
        for (int i = 0; i < N_STAGES; i++) stg[i+1] = stg[i] - (clr ? '0 : dly[i]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= '0;
            k_reg <= '0;
            up_reg <= '0;
            vcnt <= '0;
            out_valid <= 1'b0;
            data_out <= '0;
            for (int i = 0; i < N_STAGES; i++) dly[i] <= '0;
        end else begin
            if (in_ready) begin
                k_reg <= k_eff;
                for (int i = 0; i < N_STAGES; i++) dly[i] <= stg[i];
            end
            up_reg <= in_ready ? stg[N_STAGES] : '0;
            phase <= (phase + 1'b1) & mask;
            vcnt <= vcnt + {2'b0, ~vcnt[2]};
            out_valid <= vcnt[2];
            data_out <= shifted[DATA_WIDTH-1:0];
        end
    end

    for (genvar g = 0; g < N_STAGES; g++) begin : g_int
        cic_integrator #(.W(AW)) u_int (
            .CLK(CLK),
            .RST(RST),
            .clr(clr),
            .din(acc[g]),
            .acc(acc[g+1])
        );
    end
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: randomized scoreboard bench; reference is the upsampled
// input convolved with the boxcar^N impulse response, restarted on reset or factor change.
module tb_cic_interpolator;
    localparam int NS = 3;
    logic CLK = 0;
    logic RST = 1;
    logic [4:0] Interpolation_Factor = 0;
    logic in_valid = 0;
    logic in_ready;
    logic [15:0] data_in = 0;
    logic out_valid;
    logic [15:0] data_out;
    logic underrun;

    always #5 CLK = ~CLK;

    cic_interpolator dut (
        .CLK(CLK),
        .RST(RST),
        .Interpolation_Factor(Interpolation_Factor),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .out_valid(out_valid),
        .data_out(data_out),
        .underrun(underrun)
    );

    typedef struct {
        logic known;
        logic rdy;
        logic und;
        logic ov;
        logic [15:0] dout;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int h[5][64];
    int hl[5];
    int tmp[64];
    int xup[8192];
    int e = 0;
    int seg = 0;
    int m_k = 0;
    int m_phase = 0;
    int m_cnt = 0;
    logic m_ov = 0;
    logic m_known = 0;
    logic [15:0] m_dout = 0;
    logic [4:0] f_cur;
    int u;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] b);
        n_cmp++;
        if (a !== b) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %h, expected %h", n, $time, a, b);
        end
    endtask

    // Drive one cycle; push what the outputs must show now, then advance the model by one edge.
    task automatic step(input logic r, input logic [4:0] f, input logic v, input logic [15:0] d);
        exp_t x;
        longint s;
        int t, ke;
        @(negedge CLK);
        RST = r;
        Interpolation_Factor = f;
        in_valid = v;
        data_in = d;
        x.known = m_known;
        x.rdy = (m_phase == 0);
        x.und = x.rdy & ~v & ~r;
        x.ov = m_ov;
        x.dout = m_dout;
        q.push_back(x);
        if (r) begin
            m_phase = 0;
            m_k = 0;
            seg = e + 1;
            m_cnt = 0;
            m_ov = 0;
            m_dout = 0;
            xup[e] = 0;
        end else begin
            t = e - 4;
            s = 0;
            for (int j = 0; j < hl[m_k]; j++)
                if (t - j >= seg) s += longint'(h[m_k][j]) * longint'(xup[t-j]);
            s = s >>> (2 * m_k);
            m_dout = s[15:0];
            m_ov = m_cnt >= 4;
            m_cnt++;
            if (m_phase == 0) begin
                ke = (f > 4) ? 4 : int'(f);
                if (ke != m_k) begin
                    seg = e;
                    m_k = ke;
                end
                xup[e] = v ? int'($signed(d)) : 0;
            end else begin
                xup[e] = 0;
            end
            m_phase = (m_phase + 1) % (1 << m_k);
        end
        m_known = 1;
        e++;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge CLK);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.known) begin
                    chk("in_ready", 16'(in_ready), 16'(x.rdy));
                    chk("underrun", 16'(underrun), 16'(x.und));
                    chk("out_valid", 16'(out_valid), 16'(x.ov));
                    chk("data_out", data_out, x.dout);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 5; k++) begin
            h[k][0] = 1;
            hl[k] = 1;
            for (int s = 0; s < NS; s++) begin
                for (int i = 0; i < hl[k] + (1 << k) - 1; i++) begin
                    tmp[i] = 0;
                    for (int a = 0; a < (1 << k); a++)
                        if (i - a >= 0 && i - a < hl[k]) tmp[i] += h[k][i-a];
                end
                hl[k] += (1 << k) - 1;
                for (int i = 0; i < hl[k]; i++) h[k][i] = tmp[i];
            end
        end

        repeat (3) step(1, 0, 0, 0);
        repeat (20) step(0, 0, 1, 16'h1000);
        step(0, 1, 1, 16'h4000);
        repeat (15) step(0, 1, 1, 0);
        repeat (40) step(0, 2, 1, 16'h0800);
        u = 0;
        for (int i = 0; i < 24; i++) begin
            if (i > 4 && u == 0 && m_phase == 0) begin
                u = 1;
                step(0, 2, 0, 16'h0800);
            end else begin
                step(0, 2, 1, 16'h0800);
            end
        end
        repeat (48) step(0, 9, 1, 16'($urandom));
        repeat (6) step(0, 2, 1, 16'($urandom));
        repeat (30) step(0, 3, 1, 16'($urandom));
        repeat (5) step(0, 2, 1, 16'($urandom));
        for (int i = 0; i < 8 && m_phase != 2; i++) step(0, 2, 1, 16'($urandom));
        step(1, 2, 1, 16'h1234);
        repeat (20) step(0, 2, 1, 16'($urandom));
        repeat (64) step(0, 4, 1, ($urandom_range(0, 1) != 0) ? 16'h7fff : 16'h8000);
        f_cur = 5'd2;
        repeat (1500) begin
            if ($urandom_range(0, 99) < 3) f_cur = 5'($urandom_range(0, 9));
            step(($urandom_range(0, 199) == 0), f_cur, ($urandom_range(0, 9) != 0), 16'($urandom));
        end
        repeat (3) @(negedge CLK);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
